// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: pulls one row/plane word from line memory, shifts it out,
// latches it and holds OE for a binary-weighted on-time selected by the plane index.
module hub75_scan_ctrl #(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 8,
    parameter  int PLANE_BITS = 3,
    parameter  int BASE_ON    = 4,
    localparam int ROW_BITS   = ADDR_WIDTH - PLANE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  m_axi_valid,
    output logic                  m_axi_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] r0_reg,
    input  logic [DATA_WIDTH-1:0] g0_reg,
    input  logic [DATA_WIDTH-1:0] b0_reg,
    input  logic [DATA_WIDTH-1:0] r1_reg,
    input  logic [DATA_WIDTH-1:0] g1_reg,
    input  logic [DATA_WIDTH-1:0] b1_reg,
    output logic                  hub_r0,
    output logic                  hub_g0,
    output logic                  hub_b0,
    output logic                  hub_r1,
    output logic                  hub_g1,
    output logic                  hub_b1,
    output logic                  hub_clk,
    output logic                  hub_lat,
    output logic                  hub_oe_n,
    output logic [ROW_BITS-1:0]   hub_row,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int COL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int ON_W  = $clog2(BASE_ON << (2**PLANE_BITS - 1)) + 1;

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t                      r_state, w_nxt_state;
    logic [COL_W-1:0]            r_col, w_nxt_col;
    logic                        r_phase, w_nxt_phase;
    logic [ON_W-1:0]             r_on, w_nxt_on;
    logic [5:0][DATA_WIDTH-1:0]  r_words;
    logic [ADDR_WIDTH-1:0]       r_addr;

    logic                        r_ready, r_hclk, r_lat, r_oe_n, r_fd, r_busy;
    logic [5:0]                  r_data;
    logic [ROW_BITS-1:0]         r_row;

    logic                        w_hs;
    logic [ON_W-1:0]             w_on_len;
    logic [5:0][DATA_WIDTH-1:0]  w_src;
    logic [5:0]                  w_nxt_data;
    logic                        w_nxt_hclk, w_nxt_lat, w_nxt_oe_n, w_nxt_fd;
    logic                        w_nxt_busy, w_nxt_ready;

    assign w_hs     = (r_state == IDLE) && r_ready && m_axi_valid;
    assign w_on_len = ON_W'(BASE_ON) << r_addr[PLANE_BITS-1:0];

    // Words are captured on the handshake edge, so the first pixel comes straight from the inputs.
    assign w_src = w_hs ? {b1_reg, g1_reg, r1_reg, b0_reg, g0_reg, r0_reg} : r_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_phase <= 1'b0;
            r_on    <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_data  <= '0;
            r_hclk  <= 1'b0;
            r_lat   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_row   <= '0;
            r_fd    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_col   <= w_nxt_col;
            r_phase <= w_nxt_phase;
            r_on    <= w_nxt_on;
            if (w_hs) begin
                r_words <= w_src;
                r_addr  <= mem_addr;
            end
            r_ready <= w_nxt_ready;
            r_data  <= w_nxt_data;
            r_hclk  <= w_nxt_hclk;
            r_lat   <= w_nxt_lat;
            r_oe_n  <= w_nxt_oe_n;
            r_fd    <= w_nxt_fd;
            r_busy  <= w_nxt_busy;
            if (w_nxt_state == LATCH)
                r_row <= r_addr[ADDR_WIDTH-1:PLANE_BITS];
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_col   = r_col;
        w_nxt_phase = r_phase;
        w_nxt_on    = r_on;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_nxt_state = SHIFT;
                    w_nxt_col   = '0;
                    w_nxt_phase = 1'b0;
                end
            end
            SHIFT: begin
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                end else if (r_col == COL_W'(DATA_WIDTH - 1)) begin
                    w_nxt_state = BLANK;
                end else begin
                    w_nxt_col   = r_col + 1'b1;
                    w_nxt_phase = 1'b0;
                end
            end
            BLANK:   w_nxt_state = LATCH;
            LATCH: begin
                w_nxt_state = DISPLAY;
                w_nxt_on    = w_on_len - 1'b1;
            end
            DISPLAY: begin
                if (r_on == '0) w_nxt_state = IDLE;
                else            w_nxt_on    = r_on - 1'b1;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop.
    always_comb begin
        w_nxt_data = '0;
        if (w_nxt_state == SHIFT)
            for (int i = 0; i < 6; i++)
                w_nxt_data[i] = w_src[i][w_nxt_col];
        w_nxt_hclk  = (w_nxt_state == SHIFT) && w_nxt_phase;
        w_nxt_lat   = (w_nxt_state == LATCH);
        w_nxt_oe_n  = (w_nxt_state != DISPLAY);
        w_nxt_fd    = (w_nxt_state == DISPLAY) && (w_nxt_on == '0) && (&r_addr);
        w_nxt_busy  = (w_nxt_state != IDLE);
        w_nxt_ready = (w_nxt_state == IDLE) && enable;
    end

    assign m_axi_ready = r_ready;
    assign hub_r0      = r_data[0];
    assign hub_g0      = r_data[1];
    assign hub_b0      = r_data[2];
    assign hub_r1      = r_data[3];
    assign hub_g1      = r_data[4];
    assign hub_b1      = r_data[5];
    assign hub_clk     = r_hclk;
    assign hub_lat     = r_lat;
    assign hub_oe_n    = r_oe_n;
    assign hub_row     = r_row;
    assign frame_done  = r_fd;
    assign busy        = r_busy;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: per-word timing tallies compared against hand-derived values.
module tb_hub75_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, m_axi_valid;
    logic        m_axi_ready;
    logic [7:0]  mem_addr;
    logic [63:0] r0_reg, g0_reg, b0_reg, r1_reg, g1_reg, b1_reg;
    logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic        hub_clk, hub_lat, hub_oe_n, frame_done, busy;
    logic [4:0]  hub_row;

    hub75_scan_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable),
        .m_axi_valid(m_axi_valid), .m_axi_ready(m_axi_ready), .mem_addr(mem_addr),
        .r0_reg(r0_reg), .g0_reg(g0_reg), .b0_reg(b0_reg),
        .r1_reg(r1_reg), .g1_reg(g1_reg), .b1_reg(b1_reg),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_row(hub_row), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int n_rise, n_lat, lat_k, oe_first, oe_last, n_oe, n_fd, fd_k, derr, idle_k;
    int r0_first, r0_last, n_r0;
    logic [4:0] row_seen;

    // Runs one word; k counts cycles after the handshake cycle (pixel 0 low phase is k=1).
    task automatic run_word(input logic [7:0] addr, input logic [5:0][63:0] w,
                            input int drop_k, input int rst_k);
        logic pclk;
        logic [5:0] hb;
        bit got;
        int c;
        mem_addr = addr;
        r0_reg = w[0]; g0_reg = w[1]; b0_reg = w[2];
        r1_reg = w[3]; g1_reg = w[4]; b1_reg = w[5];
        enable = 1'b1;
        m_axi_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (m_axi_ready) got = 1;
        end
        if (!got) begin
            chk("hs_wait", 0, 1);
            m_axi_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs: the word must already be captured.
        m_axi_valid = 1'b0;
        mem_addr = ~addr;
        r0_reg = ~w[0]; g0_reg = ~w[1]; b0_reg = ~w[2];
        r1_reg = ~w[3]; g1_reg = ~w[4]; b1_reg = ~w[5];
        n_rise = 0; n_lat = 0; lat_k = -1; oe_first = -1; oe_last = -1; n_oe = 0;
        n_fd = 0; fd_k = -1; derr = 0; idle_k = -1; r0_first = -1; r0_last = -1; n_r0 = 0;
        pclk = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (!busy) begin
                idle_k = k;
                break;
            end
            hb = {hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0};
            if (!pclk && hub_clk) n_rise++;
            if (hub_lat) begin n_lat++; lat_k = k; end
            if (!hub_oe_n) begin
                n_oe++;
                if (oe_first < 0) oe_first = k;
                oe_last = k;
                if (hub_lat) derr++;
            end
            if (frame_done) begin n_fd++; fd_k = k; end
            if (hub_r0) begin
                n_r0++;
                if (r0_first < 0) r0_first = k;
                r0_last = k;
            end
            if (k <= 128) begin
                c = (k - 1) / 2;
                if (hub_clk !== 1'((k - 1) % 2)) derr++;
                for (int j = 0; j < 6; j++)
                    if (hb[j] !== w[j][c]) derr++;
            end else begin
                if (hb !== 6'b0 || hub_clk !== 1'b0) derr++;
            end
            row_seen = hub_row;
            pclk = hub_clk;
            if (k == drop_k) enable = 1'b0;
            if (k == rst_k) begin
                rst = 1'b1;
                return;
            end
        end
    endtask

    logic [5:0][63:0] tw;
    int cnt, hs, c0, cf, nfd;

    initial begin
        rst = 1'b1; enable = 1'b0; m_axi_valid = 1'b1; mem_addr = 8'h00;
        r0_reg = '0; g0_reg = '0; b0_reg = '0; r1_reg = '0; g1_reg = '0; b1_reg = '0;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_oe_n", hub_oe_n, 1);
            chk("rst_ready", m_axi_ready, 0);
            chk("rst_lat", hub_lat, 0);
            chk("rst_row", hub_row, 0);
            chk("rst_hclk", hub_clk, 0);
        end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_axi_ready || hub_clk || busy) cnt++;
        end
        chk("disabled_idle", cnt, 0);

        // Single pixel on r0, plane 0
        tw = '0;
        tw[0] = 64'h1;
        run_word(8'h00, tw, 0, 0);
        chk("p0_r0_cnt", n_r0, 2);
        chk("p0_r0_first", r0_first, 1);
        chk("p0_r0_last", r0_last, 2);
        chk("p0_rises", n_rise, 64);
        chk("p0_lat_k", lat_k, 130);
        chk("p0_lat_n", n_lat, 1);
        chk("p0_oe_first", oe_first, 131);
        chk("p0_oe_last", oe_last, 134);
        chk("p0_oe_n", n_oe, 4);
        chk("p0_row", row_seen, 0);
        chk("p0_data", derr, 0);
        chk("p0_idle_k", idle_k, 135);
        chk("p0_fd", n_fd, 0);

        // Mixed patterns on all six lines, row 4 plane 1
        tw[0] = 64'hA5A5_0F0F_1234_8001;
        tw[1] = 64'h8000_0000_0000_0001;
        tw[2] = 64'hFFFF_0000_FFFF_0000;
        tw[3] = 64'h0123_4567_89AB_CDEF;
        tw[4] = 64'h5555_5555_AAAA_AAAA;
        tw[5] = 64'hDEAD_BEEF_CAFE_F00D;
        run_word(8'h21, tw, 0, 0);
        chk("mix_data", derr, 0);
        chk("mix_row", row_seen, 4);
        chk("mix_oe_n", n_oe, 8);
        chk("mix_idle_k", idle_k, 139);

        // Longest plane and max row
        tw = '0;
        run_word(8'h07, tw, 0, 0);
        chk("p7_oe_n", n_oe, 512);
        chk("p7_oe_first", oe_first, 131);
        chk("p7_idle_k", idle_k, 643);
        chk("p7_row", row_seen, 0);
        run_word(8'hF9, tw, 0, 0);
        chk("r31_row", row_seen, 31);
        chk("r31_oe_n", n_oe, 8);
        chk("r31_fd", n_fd, 0);
        run_word(8'hFF, tw, 0, 0);
        chk("ff_fd_n", n_fd, 1);
        chk("ff_fd_k", fd_k, 642);

        // Enable drop at column 10
        tw[3] = 64'h0000_0000_0000_0400;
        run_word(8'h12, tw, 21, 0);
        chk("en_oe_n", n_oe, 16);
        chk("en_idle_k", idle_k, 147);
        chk("en_data", derr, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axi_ready) cnt++;
        end
        chk("en_ready_low", cnt, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("en_ready_back", m_axi_ready, 1);

        // Reset during DISPLAY of plane 7, row 4
        tw = '0;
        run_word(8'h27, tw, 0, 132);
        chk("rst_mid_oe_before", n_oe, 2);
        chk("rst_mid_row_before", row_seen, 4);
        @(negedge clk);
        chk("rst_mid_oe_n", hub_oe_n, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", m_axi_ready, 0);
        chk("rst_mid_row", hub_row, 0);
        @(negedge clk);
        chk("rst_mid_ready2", m_axi_ready, 0);
        rst = 1'b0;
        enable = 1'b1;

        // Full frame with valid held high
        mem_addr = 8'h00; m_axi_valid = 1'b1;
        hs = 0; c0 = -1; cf = -1; nfd = 0;
        for (int i = 0; i < 70000 && (hs < 256 || busy || i < 2); i++) begin
            @(negedge clk);
            if (frame_done) begin nfd++; cf = cyc; end
            if (m_axi_ready && m_axi_valid) begin
                if (hs == 0) c0 = cyc;
                hs++;
                @(posedge clk);
                #1;
                mem_addr = mem_addr + 8'h01;
                if (hs == 256) m_axi_valid = 1'b0;
            end
        end
        chk("frame_hs", hs, 256);
        chk("frame_fd_n", nfd, 1);
        chk("frame_len", cf - c0 + 1, 66176);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
